// File: rtl/sobel_edge.sv
// Sobel edge detector: 3x3 window from two line buffers, |Gx|+|Gy| thresholded
// to a 1-bit edge map with unchanged vld/sop/eop framing and 3-cycle latency.
module sobel_edge #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned THRESH = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  input  logic       din_sop,
  input  logic       din_eop,
  output logic       dout,
  output logic       dout_vld,
  output logic       dout_sop,
  output logic       dout_eop
);

  localparam int unsigned   CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  logic [CW-1:0] col, col_cur;
  logic [1:0]    row, row_cur;
  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    tap_top, tap_mid;
  logic [7:0]    w [3][3];
  logic          mask_d1, mask_d2;
  logic          vld_d1, vld_d2, sop_d1, sop_d2, eop_d1, eop_d2;
  logic [9:0]    pos_x, neg_x, pos_y, neg_y;
  logic signed [10:0] gx_n, gy_n, gx, gy;
  logic [9:0]    abs_x, abs_y;
  logic [11:0]   mag;

  // A qualified sop restarts position tracking for the pixel that carries it.
  always_comb begin
    col_cur = col;
    row_cur = row;
    if (din_sop) begin
      col_cur = '0;
      row_cur = '0;
    end
  end

  assign tap_top = lb1[col_cur];
  assign tap_mid = lb0[col_cur];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (din_vld) begin
      if (col_cur == LAST_COL) begin
        col <= '0;
        row <= (row_cur == 2'd2) ? 2'd2 : row_cur + 2'd1;
      end else begin
        col <= col_cur + CW'(1);
        row <= row_cur;
      end
    end
  end

  // Line buffers are not reset; the border mask hides stale contents.
  always_ff @(posedge clk) begin
    if (din_vld) begin
      lb0[col_cur] <= din;
      lb1[col_cur] <= tap_mid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          w[r][c] <= '0;
      mask_d1 <= 1'b0;
    end else if (din_vld) begin
      for (int unsigned r = 0; r < 3; r++) begin
        w[r][0] <= w[r][1];
        w[r][1] <= w[r][2];
      end
      w[0][2] <= tap_top;
      w[1][2] <= tap_mid;
      w[2][2] <= din;
      mask_d1 <= (row_cur == 2'd2) && (col_cur >= CW'(2));
    end
  end

  always_comb begin
    pos_x = {2'b00, w[0][2]} + {1'b0, w[1][2], 1'b0} + {2'b00, w[2][2]};
    neg_x = {2'b00, w[0][0]} + {1'b0, w[1][0], 1'b0} + {2'b00, w[2][0]};
    pos_y = {2'b00, w[2][0]} + {1'b0, w[2][1], 1'b0} + {2'b00, w[2][2]};
    neg_y = {2'b00, w[0][0]} + {1'b0, w[0][1], 1'b0} + {2'b00, w[0][2]};
    gx_n  = $signed({1'b0, pos_x}) - $signed({1'b0, neg_x});
    gy_n  = $signed({1'b0, pos_y}) - $signed({1'b0, neg_y});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx      <= '0;
      gy      <= '0;
      mask_d2 <= 1'b0;
    end else if (vld_d1) begin
      gx      <= gx_n;
      gy      <= gy_n;
      mask_d2 <= mask_d1;
    end
  end

  always_comb begin
    abs_x = gx[10] ? 10'(-gx) : gx[9:0];
    abs_y = gy[10] ? 10'(-gy) : gy[9:0];
    mag   = {2'b00, abs_x} + {2'b00, abs_y};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 1'b0;
    end else if (vld_d2) begin
      dout <= mask_d2 && (mag >= 12'(THRESH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_d1   <= 1'b0;
      vld_d2   <= 1'b0;
      dout_vld <= 1'b0;
      sop_d1   <= 1'b0;
      sop_d2   <= 1'b0;
      dout_sop <= 1'b0;
      eop_d1   <= 1'b0;
      eop_d2   <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      vld_d1   <= din_vld;
      vld_d2   <= vld_d1;
      dout_vld <= vld_d2;
      sop_d1   <= din_vld & din_sop;
      sop_d2   <= sop_d1;
      dout_sop <= sop_d2;
      eop_d1   <= din_vld & din_eop;
      eop_d2   <= eop_d1;
      dout_eop <= eop_d2;
    end
  end

endmodule

// File: tb/tb_sobel_edge.sv
// Scoreboard bench for sobel_edge: stimulus pushes frame-level expected edges,
// a negedge monitor pops and checks value, framing and 3-cycle latency.
module tb_sobel_edge;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int TH = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_vld, din_sop, din_eop;
  logic       dout, dout_vld, dout_sop, dout_eop;

  sobel_edge #(.IMG_W(W), .THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n),
    .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
    .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic e;
    logic sop;
    logic eop;
    int   cyc;
  } exp_t;

  exp_t       sb [$];
  exp_t       mx;
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] img [H][W];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Sobel on the frame image itself: weighted column/row differences.
  function automatic logic ref_edge(input int r, input int c);
    int gx, gy, wt;
    if (r < 2 || c < 2) return 1'b0;
    gx = 0;
    gy = 0;
    for (int k = 0; k < 3; k++) begin
      wt = (k == 1) ? 2 : 1;
      gx += wt * (int'(img[r-2+k][c]) - int'(img[r-2+k][c-2]));
      gy += wt * (int'(img[r][c-2+k]) - int'(img[r-2][c-2+k]));
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy) >= TH;
  endfunction

  task automatic fill(input int kind, input int amp);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = 8'(amp);
          1: img[r][c] = (c >= 4) ? 8'(amp) : 8'd0;
          2: img[r][c] = (r >= 2) ? 8'(amp) : 8'd0;
          default: img[r][c] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                           : 8'($urandom_range(100, 110));
        endcase
  endtask

  task automatic send_px(input logic [7:0] d, input logic s, input logic e,
                         input logic ex, input int gap);
    din     = d;
    din_sop = s;
    din_eop = e;
    din_vld = 1'b1;
    sb.push_back('{ex, s, e, cyc + 3});
    @(posedge clk); #1;
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    din     = 8'($urandom_range(0, 255));
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int max_gap, input int npix);
    int r, c;
    for (int i = 0; i < npix; i++) begin
      r = i / W;
      c = i % W;
      send_px(img[r][c], i == 0, i == W*H-1, ref_edge(r, c), $urandom_range(0, max_gap));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_vld"},  dout_vld, 0);
    check({tag, "_sop"},  dout_sop, 0);
    check({tag, "_eop"},  dout_eop, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_vld) begin
      if (sb.size() == 0) begin
        check("spurious_vld", 1, 0);
      end else begin
        mx = sb.pop_front();
        check("dout",    dout,     mx.e);
        check("sop",     dout_sop, mx.sop);
        check("eop",     dout_eop, mx.eop);
        check("latency", cyc,      mx.cyc);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    din     = '0;
    din_vld = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill(0, 8'h80); send_frame(0, W*H);
    fill(1, 255);   send_frame(0, W*H);
    fill(2, 255);   send_frame(0, W*H);
    fill(1, 255);   send_frame(3, W*H);
    fill(1, 15);    send_frame(1, W*H);
    fill(1, 14);    send_frame(0, W*H);

    // Reset mid-frame with results still in flight.
    fill(1, 255);
    send_frame(0, 20);
    #1 rst_n = 1'b0;
    #1 check_idle("async_rst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 check_idle("in_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Abandoned frame after 5 pixels, then a full restart at col 5.
    send_frame(0, 5);
    send_frame(0, W*H);

    for (int f = 0; f < 6; f++) begin
      fill(3, 0);
      send_frame(3, W*H);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
